shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
- Multi-cycle shift engine shared between two requesters through valid/ready ports, with round-robin arbitration.
- Performs LSL, LSR, ASR and ROL by iterating at most STEP bit positions per clock.
- Returns the result on a single response channel with backpressure.
- Sits between the ALU operand/issue logic and the writeback mux; replaces a wide combinational shifter where timing or area is tight.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 6, width of the shift-amount field; amounts up to 2^SHAMT_W-1 are accepted.
- STEP, 4, maximum bit positions shifted per cycle (1..WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  WIDTH  operand.
- req0_shamt  input  SHAMT_W  shift amount.
- req0_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op: same as requester 0.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  WIDTH  shifted result.
- resp_id  output  1  requester index that issued the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_id 0, busy 0, last_grant 1 (requester 0 wins the first tie). Reset mid-operation aborts the operation and emits no response.
- States:
  - IDLE: waits for a request.
  - SHIFT: iterates the shift.
  - DONE: holds the result until the consumer takes it.
- Arbitration, IDLE only:
  - If only one request is valid, grant it.
  - If both are valid, grant the requester not equal to last_grant.
  - reqN_ready is a combinational grant: asserted only in IDLE, only for the granted requester, and only when that requester's valid is high. Accept occurs when ready and valid are both high.
  - On accept: last_grant <= granted index; resp_id <= granted index.
- Accept latches:
  - acc <= data and op <= op.
  - rem <= effective amount:
    - LSL/LSR/ASR: min(shamt, WIDTH).
    - ROL: shamt mod WIDTH.
  - Next state is SHIFT if rem != 0, else DONE.
- SHIFT, each cycle:
  - k = min(rem, STEP).
  - acc <= acc shifted by k per op: LSL zero-fill, LSR zero-fill, ASR sign-fill from acc[WIDTH-1], ROL rotate left.
  - rem <= rem - k.
  - Go to DONE when rem - k == 0.
- DONE:
  - resp_valid=1 and resp_data=acc; both stay stable while resp_ready is low.
  - On resp_valid & resp_ready, go to IDLE and drop resp_valid.
  - No request is accepted in the same cycle the response retires (no bypass).
- Latency: accept at cycle T gives resp_valid at T+1+ceil(rem/STEP); rem=0 gives T+1.
- Minimum issue interval is latency+1.
- Requests arriving while busy are held by the requester; ready stays 0.
- ASR with effective amount WIDTH yields all copies of the sign bit.
- LSL/LSR with effective amount WIDTH yields 0.
- resp_data updates only on the transition into DONE. Outside DONE it keeps its last value and is don't-care.

Decomposition:
- Package shift_pkg:
  - op enum (OP_LSL, OP_LSR, OP_ASR, OP_ROL).
  - state enum (IDLE, SHIFT, DONE).
  - Width-agnostic helper functions for the effective-amount computation.
- Sub-module shift_step: combinational one-iteration shifter. Inputs acc, op, k (0..STEP); output next acc. Instantiated once.
- Arbiter and FSM stay in shift_sched.

Test Plan:
1. req0 LSL, data 0x0000_0001, shamt 5, resp_ready=1 -> accept at T, resp_valid at T+3, resp_data 0x0000_0020, resp_id 0.
2. req1 ASR, data 0x8000_0000, shamt 40 -> saturates to 32, resp_valid at T+9, resp_data 0xFFFF_FFFF, resp_id 1.
3. req0 ROL, data 0x8000_0001, shamt 33 -> effective 1, resp_data 0x0000_0003 at T+2. Separately, ROL shamt 32 and LSR shamt 0 each -> data unchanged at T+1.
4. Both requesters held valid from reset, each issuing 3 ops -> grant order 0,1,0,1,0,1. reqN_ready is never high while busy.
5. resp_ready held low 5 cycles in DONE -> resp_valid, resp_data and resp_id stable. Both readys 0, busy 1. Response retires on the first resp_ready high.
6. rst pulsed for one cycle during SHIFT of LSL shamt 20 -> next cycle state IDLE, resp_valid 0, busy 0. No response for the aborted op; the next request is accepted normally.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the iterative shift engine.
// Holds the op/state encodings and the effective shift-amount rule.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Linear shifts saturate at the data width; rotates wrap modulo the width.
    function automatic int unsigned eff_amount(input int unsigned shamt,
                                               input op_e op,
                                               input int unsigned width);
        if (op == OP_ROL)
            return shamt % width;
        return (shamt > width) ? width : shamt;
    endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Two request channels plus one response channel of the shared shift engine.
// The engine connects through slave, the requesters/consumer through master.
interface shift_sched_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 6
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_data;
    logic [SHAMT_W-1:0] req0_shamt;
    logic [1:0]         req0_op;

    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_data;
    logic [SHAMT_W-1:0] req1_shamt;
    logic [1:0]         req1_op;

    logic               resp_valid;
    logic               resp_ready;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_id;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op,
        input  req1_valid, req1_data, req1_shamt, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op,
        output req1_valid, req1_data, req1_shamt, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/shift_sched_step.sv
// One iteration of the shifter: moves acc by k (0..STEP) positions for the given op.
// k is narrow, so each shift below is a small mux tree rather than a full barrel.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] acc,
    input  op_e              op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] nxt
);

    logic signed [WIDTH-1:0] sacc;
    assign sacc = acc;

    // For k == 0 the rotate's right-shift term is by WIDTH and contributes zero.
    always_comb begin
        nxt = acc;
        case (op)
            OP_LSL:  nxt = acc << k;
            OP_LSR:  nxt = acc >> k;
            OP_ASR:  nxt = sacc >>> k;
            OP_ROL:  nxt = (acc << k) | (acc >> (WIDTH - int'(k)));
            default: nxt = acc;
        endcase
    end

endmodule

// File: rtl/shift_sched.sv
// Shared multi-cycle shift engine: round-robin arbitration between two requesters,
// iterative shifting of up to STEP bits per clock, and one backpressured response.
module shift_sched
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 6,
    parameter int STEP    = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_sched_if.slave  bus,
    output logic          busy
);

    localparam int REM_W = $clog2(WIDTH + 1);
    localparam int KW    = $clog2(STEP + 1);

    state_e             state, state_nxt;
    logic               last_grant;
    logic [WIDTH-1:0]   acc;
    op_e                op_q;
    logic [REM_W-1:0]   rem;

    logic               grant0, grant1, accept, sel_id;
    logic [WIDTH-1:0]   sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    op_e                sel_op;
    logic [REM_W-1:0]   rem_eff, rem_nxt;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_out;

    // Round-robin: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign sel_id    = grant1;
    assign sel_data  = grant1 ? bus.req1_data  : bus.req0_data;
    assign sel_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;
    assign sel_op    = op_e'(grant1 ? bus.req1_op : bus.req0_op);
    assign rem_eff   = REM_W'(eff_amount(32'(sel_shamt), sel_op, 32'(WIDTH)));

    assign k       = (rem > REM_W'(STEP)) ? KW'(STEP) : KW'(rem);
    assign rem_nxt = rem - REM_W'(k);

    shift_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .acc (acc),
        .op  (op_q),
        .k   (k),
        .nxt (step_out)
    );

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                accept         = grant0 || grant1;
                if (accept)
                    state_nxt = (rem_eff == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_nxt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                if (bus.resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.resp_valid = (state == DONE);
    assign busy           = (state != IDLE);

    // Control and the visible response registers; resp_data loads only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.resp_id   <= 1'b0;
            bus.resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant  <= sel_id;
                bus.resp_id <= sel_id;
                if (rem_eff == '0)
                    bus.resp_data <= sel_data;
            end else if (state == SHIFT && rem_nxt == '0) begin
                bus.resp_data <= step_out;
            end
        end
    end

    // Working operand registers carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc  <= sel_data;
            op_q <= sel_op;
            rem  <= rem_eff;
        end else if (state == SHIFT) begin
            acc <= step_out;
            rem <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: a vector table of single operations plus
// hand-written sequences for arbitration, backpressure and mid-operation reset.
module tb_shift_sched;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    shift_sched_if #(.WIDTH(32), .SHAMT_W(6)) bus ();

    shift_sched #(.WIDTH(32), .SHAMT_W(6), .STEP(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] data;
        logic [5:0]  shamt;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];
    int   applied     = 0;
    int   miscompares = 0;
    int   bad_ready   = 0;

    always @(negedge clk)
        if (!rst && busy && (bus.req0_ready || bus.req1_ready))
            bad_ready++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [1:0] op,
                             input logic [31:0] d, input logic [5:0] sh);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_data = d; bus.req1_shamt = sh;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_data = d; bus.req0_shamt = sh;
        end
    endtask

    // Call at posedge+#1 of the cycle after acceptance; waits for resp_valid and checks it.
    task automatic wait_resp(input string name, input logic [31:0] exp_data,
                             input logic exp_id, input int exp_lat);
        int  lat;
        logic got;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, " resp seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
            check({name, " data"}, bus.resp_data, exp_data);
            check({name, " id"}, 32'(bus.resp_id), 32'(exp_id));
        end
    endtask

    // Call at posedge+#1 in IDLE with resp_ready high; leaves the bench at posedge+#1 after retire.
    task automatic issue(input string name, input logic id, input logic [1:0] op,
                         input logic [31:0] d, input logic [5:0] sh,
                         input logic [31:0] exp_data, input int exp_lat);
        logic acc_ok;
        acc_ok = 1'b0;
        drive_req(id, 1'b1, op, d, sh);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                acc_ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, " accept"}, 32'(acc_ok), 32'd1);
        @(posedge clk); #1;
        drive_req(id, 1'b0, op, d, sh);
        if (acc_ok) begin
            wait_resp(name, exp_data, id, exp_lat);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [2];
        logic g;
        logic seen;
        int rv_count;

        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0001, 6'd5,  32'h0000_0020, 3};
        vecs[1]  = '{1'b1, 2'b10, 32'h8000_0000, 6'd40, 32'hFFFF_FFFF, 9};
        vecs[2]  = '{1'b0, 2'b11, 32'h8000_0001, 6'd33, 32'h0000_0003, 2};
        vecs[3]  = '{1'b1, 2'b11, 32'h1234_5678, 6'd32, 32'h1234_5678, 1};
        vecs[4]  = '{1'b0, 2'b01, 32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1};
        vecs[5]  = '{1'b1, 2'b00, 32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 9};
        vecs[6]  = '{1'b0, 2'b01, 32'h8000_0000, 6'd31, 32'h0000_0001, 9};
        vecs[7]  = '{1'b1, 2'b10, 32'h7FFF_FFF0, 6'd4,  32'h07FF_FFFF, 2};
        vecs[8]  = '{1'b0, 2'b11, 32'h0000_000F, 6'd63, 32'h8000_0007, 9};
        vecs[9]  = '{1'b1, 2'b10, 32'h8000_0000, 6'd3,  32'hF000_0000, 2};
        vecs[10] = '{1'b0, 2'b00, 32'h0000_00FF, 6'd8,  32'h0000_FF00, 3};
        vecs[11] = '{1'b1, 2'b01, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 9};

        rst = 1'b1;
        bus.resp_ready = 1'b1;
        drive_req(1'b0, 1'b0, 2'b00, 32'h0, 6'd0);
        drive_req(1'b1, 1'b0, 2'b00, 32'h0, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset busy",       32'(busy),           32'd0);
        check("reset resp_data",  bus.resp_data,       32'h0);
        check("reset resp_id",    32'(bus.resp_id),    32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            issue($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].data,
                  vecs[i].shamt, vecs[i].exp_data, vecs[i].exp_lat);

        // Both requesters valid from reset: grants must alternate starting with 0.
        rst = 1'b1;
        drive_req(1'b0, 1'b1, 2'b00, 32'h0000_000A, 6'd0);
        drive_req(1'b1, 1'b1, 2'b00, 32'h0000_000B, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt[0] = 3;
        cnt[1] = 3;
        for (int i = 0; i < 6; i++) begin
            seen = 1'b0;
            g    = 1'b0;
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    seen = 1'b1;
                    g    = bus.req1_ready;
                    check($sformatf("rr%0d single ready", i),
                          32'(bus.req0_ready && bus.req1_ready), 32'd0);
                    break;
                end
                @(posedge clk); #1;
            end
            check($sformatf("rr%0d granted", i), 32'(seen), 32'd1);
            if (!seen) break;
            check($sformatf("rr%0d order", i), 32'(g), 32'(i % 2));
            @(posedge clk); #1;
            cnt[g]--;
            if (cnt[g] == 0)
                drive_req(g, 1'b0, 2'b00, 32'h0, 6'd0);
            wait_resp($sformatf("rr%0d", i), g ? 32'h0000_000B : 32'h0000_000A, g, 1);
            @(posedge clk); #1;
        end
        drive_req(1'b0, 1'b0, 2'b00, 32'h0, 6'd0);
        drive_req(1'b1, 1'b0, 2'b00, 32'h0, 6'd0);

        // Backpressure: response held five cycles, no bypass on the retiring cycle.
        bus.resp_ready = 1'b0;
        drive_req(1'b0, 1'b1, 2'b00, 32'h0000_0003, 6'd4);
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 2'b00, 32'h0, 6'd0);
        drive_req(1'b1, 1'b1, 2'b01, 32'h0000_0100, 6'd8);
        wait_resp("bp first", 32'h0000_0030, 1'b0, 2);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("bp%0d resp_valid", j), 32'(bus.resp_valid), 32'd1);
            check($sformatf("bp%0d resp_data", j),  bus.resp_data,       32'h0000_0030);
            check($sformatf("bp%0d resp_id", j),    32'(bus.resp_id),    32'd0);
            check($sformatf("bp%0d readys", j),
                  32'(bus.req0_ready || bus.req1_ready), 32'd0);
            check($sformatf("bp%0d busy", j),       32'(busy),           32'd1);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp retire no bypass", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp retired resp_valid", 32'(bus.resp_valid), 32'd0);
        check("bp next ready1",        32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 2'b00, 32'h0, 6'd0);
        wait_resp("bp second", 32'h0000_0001, 1'b1, 3);
        @(posedge clk); #1;

        // Reset pulsed during a long LSL aborts it silently.
        drive_req(1'b0, 1'b1, 2'b00, 32'h0000_0001, 6'd20);
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 2'b00, 32'h0, 6'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort busy",       32'(busy),           32'd0);
        rv_count = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.resp_valid) rv_count++;
        end
        check("abort no response", 32'(rv_count), 32'd0);
        @(posedge clk); #1;
        issue("after abort", 1'b0, 2'b00, 32'h0000_0001, 6'd2, 32'h0000_0004, 2);

        check("ready while busy", 32'(bad_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
